// File: rtl/ufp_pkg.sv
// Shared unsigned fixed-point definitions for the ufp_* arithmetic blocks.
// Word is UQ(IW).(QW); products carry the full double-width result.
package ufp_pkg;

   localparam int unsigned IW = 16;
   localparam int unsigned QW = 16;
   localparam int unsigned W  = IW + QW;
   localparam int unsigned PW = 2 * W;

   typedef logic [W-1:0]  ufp_word_t;
   typedef logic [PW-1:0] ufp_prod_t;

   localparam ufp_word_t UFP_MAX = '1;

   // One pipeline payload: full product plus the overflow mode it was issued with.
   typedef struct packed {
      ufp_prod_t prod;
      logic      sat;
   } ufp_beat_t;

   // Any set bit above the result window means the value cannot be represented.
   function automatic logic ufp_overflow(ufp_prod_t prod);
      return |prod[PW-1 -: IW];
   endfunction

endpackage

// File: rtl/ufp_mul_pipe_if.sv
// Operand/result stream bundle for ufp_mul_pipe: input beat handshake and result handshake.
interface ufp_mul_pipe_if;
   import ufp_pkg::*;

   logic      in_valid;
   logic      in_ready;
   ufp_word_t x;
   ufp_word_t y;
   logic      sat;
   logic      out_valid;
   logic      out_ready;
   ufp_word_t out;
   logic      clipping;

   modport master (
      output in_valid, x, y, sat, out_ready,
      input  in_ready, out_valid, out, clipping
   );

   modport slave (
      input  in_valid, x, y, sat, out_ready,
      output in_ready, out_valid, out, clipping
   );

endinterface

// File: rtl/ufp_pipe_stage.sv
// One register slice of the multiplier pipeline: valid bit plus {product, sat} payload,
// loaded only when the global advance enable is high.
module ufp_pipe_stage
   import ufp_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   input  logic      in_vld,
   input  ufp_beat_t in_data,
   output logic      out_vld,
   output ufp_beat_t out_data
);

   logic      vld_q;
   ufp_beat_t data_q;

   // Payload is cleared too so the result port reads zero straight after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else if (en) begin
         vld_q  <= in_vld;
         data_q <= in_data;
      end
   end

   assign out_vld  = vld_q;
   assign out_data = data_q;

endmodule

// File: rtl/ufp_mul_pipe.sv
// Pipelined UQ(IW).(QW) multiplier with valid/ready handshake and per-beat wrap/saturate.
// Define UFP_MUL_PIPE_ROUND_EN for round-half-up instead of truncation (same latency).
module ufp_mul_pipe
   import ufp_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input logic            clk,
   input logic            rst,
   ufp_mul_pipe_if.slave  bus
);

   logic      adv;
   logic      vld  [STAGES+1];
   ufp_beat_t beat [STAGES+1];

   // Single global stall: everything shifts together, bubbles included.
   assign adv          = !vld[STAGES] || bus.out_ready;
   assign bus.in_ready = adv;

   assign vld[0] = bus.in_valid;

   always_comb begin
      beat[0]      = '0;
      beat[0].prod = ufp_prod_t'(bus.x) * ufp_prod_t'(bus.y);
      beat[0].sat  = bus.sat;
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      ufp_pipe_stage u_stage (
         .clk      (clk),
         .rst      (rst),
         .en       (adv),
         .in_vld   (vld[i]),
         .in_data  (beat[i]),
         .out_vld  (vld[i+1]),
         .out_data (beat[i+1])
      );
   end

   ufp_prod_t   prod;
   logic        sat_last;
   logic [W:0]  res_ext;
   logic        ovf;
   logic        unused_lsb;

   assign prod       = beat[STAGES].prod;
   assign sat_last   = beat[STAGES].sat;
   assign unused_lsb = ^prod[QW-1:0];

   // Overflow detect and saturate select act on the last stage's registered product.
   always_comb begin
      res_ext = {1'b0, prod[QW +: W]};
`ifdef UFP_MUL_PIPE_ROUND_EN
      res_ext = {1'b0, prod[QW +: W]} + {{W{1'b0}}, prod[QW-1]};
`endif
      ovf = ufp_overflow(prod) | res_ext[W];
   end

   always_comb begin
      bus.out_valid = vld[STAGES];
      bus.clipping  = ovf;
      bus.out       = (ovf && sat_last) ? UFP_MAX : res_ext[W-1:0];
   end

endmodule

// File: tb/tb_ufp_mul_pipe.sv
// Self-checking bench for ufp_mul_pipe (Q16.16, STAGES=2) against a plain-arithmetic model.
module tb_ufp_mul_pipe;

   typedef struct {
      logic [31:0] out;
      logic        clip;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_pop = 0;

   res_t        exp_q[$];
   logic [31:0] xs [256];
   logic [31:0] ys [256];
   logic        ss [256];
   bit          accepted;
   bit          stall_prev;
   logic [33:0] held;

   ufp_mul_pipe_if bus ();

   ufp_mul_pipe #(.STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: exact product, shift into Q16.16, optional half-up rounding, range test.
   function automatic res_t model(logic [31:0] a, logic [31:0] b, logic s);
      res_t            r;
      longint unsigned p;
      longint unsigned q;
      p = longint'({32'd0, a}) * longint'({32'd0, b});
      q = p >> 16;
`ifdef UFP_MUL_PIPE_ROUND_EN
      q = q + ((p >> 15) & 64'd1);
`endif
      r.clip = (q > 64'h0000_0000_FFFF_FFFF);
      r.out  = (r.clip && s) ? 32'hFFFF_FFFF : q[31:0];
      return r;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at the falling edge, score pops/pushes, return 1ns after rising edge.
   task automatic step();
      res_t e;
      @(negedge clk);
      if (stall_prev) check("hold_stable", {bus.out_valid, bus.clipping, bus.out}, held);
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            n_pop++;
            check("out", 64'(bus.out), 64'(e.out));
            check("clipping", 64'(bus.clipping), 64'(e.clip));
         end
      end
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) exp_q.push_back(model(bus.x, bus.y, bus.sat));
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.out_valid, bus.clipping, bus.out};
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      stall_prev = 1'b0;
   endtask

   task automatic single(logic [31:0] a, logic [31:0] b, logic s, logic [31:0] eo, logic ec,
                         string tag);
      bus.in_valid = 1'b1;
      bus.x        = a;
      bus.y        = b;
      bus.sat      = s;
      step();
      bus.in_valid = 1'b0;
      step();
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_out"}, 64'(bus.out), 64'(eo));
      check({tag, "_clip"}, 64'(bus.clipping), 64'(ec));
      step();
   endtask

   // mode 0: ready high; mode 1: 3-cycle stall on first result; mode 2: random valid/ready.
   task automatic run_stream(int n, int mode);
      int idx    = 0;
      int cyc    = 0;
      int stall  = 0;
      bit seen   = 0;
      bit hold_v = 0;
      n_pop = 0;
      while ((idx < n || exp_q.size() != 0) && cyc < 2000) begin
         bus.in_valid = (idx < n) && (hold_v || mode != 2 || $urandom_range(0, 3) != 0);
         if (idx < n) begin
            bus.x   = xs[idx];
            bus.y   = ys[idx];
            bus.sat = ss[idx];
         end
         if (mode == 1 && !seen && bus.out_valid) begin
            seen  = 1;
            stall = 3;
         end
         if (mode == 2) bus.out_ready = ($urandom_range(0, 2) != 0);
         else           bus.out_ready = (stall == 0);
         #1;
         if (stall > 0) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         step();
         if (accepted) idx++;
         hold_v = bus.in_valid && !accepted;
         if (stall > 0) stall--;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("stream_complete", 64'(idx == n && exp_q.size() == 0), 64'd1);
      check("stream_pops", 64'(n_pop), 64'(n));
      if (mode == 1) check("stall_seen", 64'(seen), 64'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.x         = '0;
      bus.y         = '0;
      bus.sat       = 1'b0;
      stall_prev    = 1'b0;
      held          = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out", 64'(bus.out), 64'd0);
      check("rst_clipping", 64'(bus.clipping), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // 2.0 * 3.0 with latency checks: not valid one cycle after accept, valid after two.
      bus.in_valid = 1'b1;
      bus.x        = 32'h0002_0000;
      bus.y        = 32'h0003_0000;
      bus.sat      = 1'b0;
      step();
      bus.in_valid = 1'b0;
      check("lat1_valid", 64'(bus.out_valid), 64'd0);
      step();
      check("lat2_valid", 64'(bus.out_valid), 64'd1);
      check("mul6_out", 64'(bus.out), 64'h0006_0000);
      check("mul6_clip", 64'(bus.clipping), 64'd0);
      step();
      check("mul6_drain", 64'(bus.out_valid), 64'd0);

      single(32'h0100_0000, 32'h0100_0000, 1'b0, 32'h0000_0000, 1'b1, "ovf_wrap");
      single(32'h0100_0000, 32'h0100_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, "ovf_sat");
`ifdef UFP_MUL_PIPE_ROUND_EN
      single(32'h0000_0001, 32'h0000_8000, 1'b0, 32'h0000_0001, 1'b0, "half_lsb");
      single(32'hFFFF_FFFF, 32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, "max_times_one");
`else
      single(32'h0000_0001, 32'h0000_8000, 1'b0, 32'h0000_0000, 1'b0, "half_lsb");
      single(32'hFFFF_FFFF, 32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, "max_times_one");
`endif

      // Eight back-to-back beats with a three-cycle downstream stall.
      for (int i = 0; i < 8; i++) begin
         xs[i] = $urandom >> $urandom_range(8, 20);
         ys[i] = $urandom >> $urandom_range(8, 20);
         ss[i] = 1'($urandom_range(0, 1));
      end
      run_stream(8, 1);

      // Reset with two beats in flight: nothing may emerge afterwards.
      bus.in_valid = 1'b1;
      bus.x        = 32'h0004_0000;
      bus.y        = 32'h0005_0000;
      step();
      step();
      do_reset();
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
      end

      // Overflowing operands with alternating sat: each result follows its own mode.
      for (int i = 0; i < 6; i++) begin
         xs[i] = 32'h0100_0000 + $urandom_range(0, 32'hFFFF);
         ys[i] = 32'h0200_0000 + $urandom_range(0, 32'hFFFF);
         ss[i] = 1'(i % 2);
      end
      run_stream(6, 0);

      // Random traffic, random backpressure, mixed magnitudes.
      for (int i = 0; i < 200; i++) begin
         xs[i] = $urandom >> $urandom_range(0, 24);
         ys[i] = $urandom >> $urandom_range(0, 24);
         ss[i] = 1'($urandom_range(0, 1));
      end
      run_stream(200, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
